// File: rtl/pe_8x4_16bit.sv
// Fixed-point processing element: NOUT dot products of one shared NDATA-term data vector,
// two-stage pipeline. Define PE_ROUND_EN for round-half-up instead of floor before saturation.
module pe_8x4_16bit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDATA = 8,
  parameter int unsigned NOUT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [WIDTH*NDATA-1:0]        DATA,
  input  logic [WIDTH*NDATA*NOUT-1:0]   WEIGHT,
  output logic [WIDTH*NOUT-1:0]         Q
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned AW    = PW + $clog2(NDATA);
  localparam int unsigned NPROD = NDATA * NOUT;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef PE_ROUND_EN
  localparam logic signed [AW-1:0] RND_HALF = {{(AW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
`endif

  // Stage 1: full-precision products
  logic signed [PW-1:0] prod_d [NPROD];
  logic signed [PW-1:0] prod_q [NPROD];

  always_comb begin
    for (int k = 0; k < NPROD; k++) begin
      prod_d[k] = $signed(DATA[(k % NDATA)*WIDTH +: WIDTH]) *
                  $signed(WEIGHT[k*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NPROD; k++) begin
        prod_q[k] <= '0;
      end
    end else if (ce) begin
      for (int k = 0; k < NPROD; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  // Stage 2: accumulate, scale back to Q1.(WIDTH-1), saturate
  logic signed [AW-1:0]             sum [NOUT];
  logic signed [AW-1:0]             shr [NOUT];
  logic [NOUT-1:0][WIDTH-1:0]       q_d;
  logic [NOUT-1:0][WIDTH-1:0]       q_q;

  always_comb begin
    for (int j = 0; j < NOUT; j++) begin
      sum[j] = '0;
      for (int i = 0; i < NDATA; i++) begin
        sum[j] = sum[j] + {{(AW-PW){prod_q[j*NDATA+i][PW-1]}}, prod_q[j*NDATA+i]};
      end
`ifdef PE_ROUND_EN
      sum[j] = sum[j] + RND_HALF;
`endif
      // Arithmetic shift floors toward minus infinity
      shr[j] = sum[j] >>> (WIDTH - 1);
      if (shr[j] > SAT_MAX) begin
        q_d[j] = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (shr[j] < SAT_MIN) begin
        q_d[j] = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        q_d[j] = shr[j][WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (ce) begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_pe_8x4_16bit.sv
// Directed bench for pe_8x4_16bit: reset, saturation, nominal, row independence,
// rounding, clock-enable stall and mid-stream reset with hand-computed expectations.
module tb_pe_8x4_16bit;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [127:0]  data;
  logic [511:0]  weight;
  logic [63:0]   q;

  int checks = 0;
  int errors = 0;

  logic [63:0] round_exp;
  logic [63:0] set_a_exp;
  logic [63:0] set_b_exp;
  logic [63:0] set_c_exp;

  pe_8x4_16bit dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .DATA   (data),
    .WEIGHT (weight),
    .Q      (q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] dval, input logic [15:0] wval);
    for (int i = 0; i < 8; i++) data[i*16 +: 16] = dval;
    for (int k = 0; k < 32; k++) weight[k*16 +: 16] = wval;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++) weight[i*32 +: 32] = $urandom;
  endtask

  task automatic check(input string tag, input logic [63:0] exp);
    checks++;
    assert (q === exp) else begin
      errors++;
      $error("FAIL %s: observed Q=%h expected %h", tag, q, exp);
    end
  endtask

  task automatic check_w(input string tag, input int j, input logic [15:0] exp);
    checks++;
    assert (q[j*16 +: 16] === exp) else begin
      errors++;
      $error("FAIL %s: observed Q[%0d]=%h expected %h", tag, j, q[j*16 +: 16], exp);
    end
  endtask

  initial begin
`ifdef PE_ROUND_EN
    round_exp = 64'h0000_0000_0000_0001;
`else
    round_exp = 64'h0000_0000_0000_0000;
`endif
    set_a_exp = {4{16'h4000}};
    set_b_exp = {4{16'h1000}};
    set_c_exp = {16'hF000, 16'h0C00, 16'h0800, 16'h0400};

    // Reset with ce high and random inputs
    rst = 1'b1;
    ce  = 1'b1;
    randomize_inputs();
    tick();
    tick();
    check("reset", 64'h0);

    // Negative saturation, also checks refill latency after rst falls
    rst = 1'b0;
    set_all(16'h7B2A, 16'h8F04);
    tick();
    check("refill_edge1", 64'h0);
    tick();
    check("neg_sat", {4{16'h8000}});

    // Nominal value
    set_all(16'h4000, 16'h1000);
    tick();
    tick();
    check("nominal", {4{16'h4000}});

    // Positive saturation and row independence
    set_all(16'h8000, 16'h0000);
    for (int i = 0; i < 8; i++) weight[i*16 +: 16] = 16'h8000;
    weight[16*16 +: 16] = 16'h7FFF;
    for (int i = 0; i < 8; i++) weight[(24+i)*16 +: 16] = 16'h4000;
    tick();
    tick();
    check_w("pos_sat_row0", 0, 16'h7FFF);
    check_w("zero_row1", 1, 16'h0000);
    check_w("single_term_row2", 2, 16'h8001);
    check_w("neg_sat_row3", 3, 16'h8000);

    // Rounding of a half-LSB result
    set_all(16'h0000, 16'h0000);
    data[15:0]   = 16'h0001;
    weight[15:0] = 16'h4000;
    tick();
    tick();
    check("rounding", round_exp);

    // Clock-enable stall between sets A and B
    set_all(16'h4000, 16'h1000);
    tick();
    check("set_a_edge", round_exp);
    ce = 1'b0;
    for (int s = 0; s < 3; s++) begin
      randomize_inputs();
      tick();
      check("stall_hold", round_exp);
    end
    ce = 1'b1;
    set_all(16'h1000, 16'h1000);
    tick();
    check("stream_a", set_a_exp);
    set_all(16'h0000, 16'h0000);
    data[15:0] = 16'h4000;
    weight[0*128 +: 16] = 16'h0800;
    weight[1*128 +: 16] = 16'h1000;
    weight[2*128 +: 16] = 16'h1800;
    weight[3*128 +: 16] = 16'hE000;
    tick();
    check("stream_b", set_b_exp);
    randomize_inputs();
    tick();
    check("stream_c", set_c_exp);

    // Reset takes priority over a low ce and flushes both stages
    ce  = 1'b0;
    rst = 1'b1;
    tick();
    check("reset_over_ce", 64'h0);
    rst = 1'b0;
    ce  = 1'b1;
    set_all(16'h4000, 16'h1000);
    tick();
    check("post_reset_flush", 64'h0);
    tick();
    check("post_reset_refill", {4{16'h4000}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
